gpu_ram_port_b_arbiter: RTL and testbench
=========================================

GPU_RAM_PORT_B_ARBITER -- requirements
Module: gpu_ram_port_b_arbiter

Interface
REQ-001 Parameters, one per line:
  ADDR_SIZE, 14, RAM address width.
  NUM_WORDS, 2**ADDR_SIZE, valid RAM words.
  MAX_BURST, 8, max consecutive accesses per grant (1..255).
REQ-002 Ports, one per line:
  clk  in  1  single clock, rising edge; RAM clk_b is tied to clk.
  rst  in  1  asynchronous, active-high reset.
  host_req  in  1  host access request; hold until host_ack.
  host_wr  in  1  1=write, 0=read.
  host_addr  in  20  byte address.
  host_wdata  in  8  write data.
  host_ack  out  1  access accepted this cycle (combinational).
  host_rd_valid  out  1  host_rdata valid, one-cycle pulse.
  host_rdata  out  8  read data.
  geo_req, geo_wr, geo_addr, geo_wdata, geo_ack, geo_rd_valid, geo_rdata  same as host_* for the geometry/blitter requester.
  ram_addr_b  out  20  RAM port B address, registered.
  ram_wr_en_b  out  1  RAM port B write enable, registered.
  ram_data_in_b  out  8  RAM port B write data, registered.
  ram_data_out_b  in  8  RAM port B read data (q_b).

Function
REQ-003 FSM states: IDLE, OWN_HOST, OWN_GEO.
REQ-004 IDLE: no access accepted; if any req, move to OWN_x of the arbitration winner next cycle.
REQ-005 Both reqs in IDLE: winner SHALL be the requester that did not own last (round-robin per REQ-020); first arbitration after reset SHALL pick host.
REQ-006 OWN_x: x_ack SHALL equal x_req; the other requester's ack SHALL be 0.
REQ-007 Burst counter SHALL clear on entering OWN_x and increment per accepted access.
REQ-008 OWN_x SHALL return to IDLE after the cycle in which x_req is 0 or the counter reaches MAX_BURST.
REQ-009 Access accepted in cycle N: ram_addr_b/ram_wr_en_b/ram_data_in_b SHALL present it in cycle N+1; in all other cycles ram_wr_en_b SHALL be 0.
REQ-010 Read accepted in cycle N: x_rd_valid SHALL pulse in cycle N+3 with x_rdata = ram_data_out_b (fixed latency 3, one read per cycle pipelined).
REQ-011 Read-return routing SHALL use a 3-stage valid+owner-ID tag pipe; routing SHALL NOT depend on current FSM state.
REQ-012 addr >= NUM_WORDS: access SHALL be acked; writes SHALL drive ram_wr_en_b=0; reads SHALL return x_rdata=8'h00 with normal rd_valid timing.
REQ-013 x_rdata SHALL hold its last value when rd_valid is 0.
REQ-014 Owner deasserts req mid-burst: no access that cycle, IDLE next cycle; in-flight reads SHALL still return.

Reset
REQ-015 rst SHALL asynchronously force: state IDLE, burst counter 0, last owner = geo, tag pipe cleared, ram_addr_b 0, ram_wr_en_b 0, ram_data_in_b 0, host_rdata/geo_rdata 0, host_rd_valid/geo_rd_valid 0.
REQ-016 Reads in flight at reset SHALL be dropped (no rd_valid after reset).
REQ-017 acks SHALL be 0 while rst is high.

Configuration
REQ-018 Macro GPU_RAM_ARB_ROUND_ROBIN_EN selects the arbitration policy.
REQ-019 Undefined: fixed priority, host wins every IDLE arbitration.
REQ-020 Defined: round-robin per REQ-005.

Structure
REQ-021 Package gpu_ram_arb_pkg SHALL hold the FSM state enum, requester-ID type (HOST=0, GEO=1) and constant RD_LATENCY=3.
REQ-022 Tag pipe SHALL be sub-module gpu_ram_rd_tag_pipe (depth RD_LATENCY, valid+ID in, valid+ID out).

Verification
REQ-023 Host read addr 0x0010 (RAM=0x5A) alone -> host_ack cycle N, ram_addr_b=0x0010 cycle N+1, host_rd_valid with 0x5A cycle N+3.
REQ-024 Both req continuously, MAX_BURST=8, round-robin -> 8 host acks, 1 IDLE cycle, 8 geo acks, repeating; fixed priority -> geo never acked.
REQ-025 Geo write 0x3FFF=0xA5 then host read 0x3FFF -> host_rdata=0xA5; geo write 0x4000 -> acked, ram_wr_en_b stays 0.
REQ-026 Host burst of 4 back-to-back reads, req drops after 3 -> 3 acks, IDLE next cycle, 3 rd_valid pulses in order.
REQ-027 rst asserted one cycle after a read accept -> all outputs reset immediately, no rd_valid afterwards, next arbitration picks host.

Source files
------------

// File: rtl/gpu_ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpu_ram_arb_pkg
// Description : Shared types and constants for the GPU RAM port B arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package gpu_ram_arb_pkg;

    localparam int RD_LATENCY = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OWN_HOST = 2'd1,
        OWN_GEO  = 2'd2
    } arb_state_t;

    typedef enum logic {
        HOST = 1'b0,
        GEO  = 1'b1
    } req_id_t;

endpackage
`default_nettype wire

// File: rtl/gpu_ram_rd_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module      : gpu_ram_rd_tag_pipe
// Description : Fixed-depth valid + requester-ID shift pipe that tracks reads
//               in flight so returns route independently of arbiter state.
// Revision    : 1.0 - initial release
// ============================================================================
module gpu_ram_rd_tag_pipe
    import gpu_ram_arb_pkg::*;
#(
    parameter int DEPTH = RD_LATENCY
)(
    input  logic    clk,
    input  logic    rst,
    input  logic    in_valid,
    input  req_id_t in_id,
    output logic    out_valid,
    output req_id_t out_id
);

    logic    [DEPTH-1:0] r_valid;
    req_id_t             r_id [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_id[i] <= HOST;
            end
        end else begin
            r_valid[0] <= in_valid;
            r_id[0]    <= in_id;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_id[i]    <= r_id[i-1];
            end
        end
    end

    assign out_valid = r_valid[DEPTH-1];
    assign out_id    = r_id[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/gpu_ram_port_b_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : gpu_ram_port_b_arbiter
// Description : Two-requester (host, geometry) burst arbiter for RAM port B
//               with registered RAM outputs and a fixed 3-cycle read return.
//               GPU_RAM_ARB_ROUND_ROBIN_EN selects round-robin instead of
//               fixed host priority.
// Revision    : 1.0 - initial release
// ============================================================================
module gpu_ram_port_b_arbiter
    import gpu_ram_arb_pkg::*;
#(
    parameter int ADDR_SIZE = 14,
    parameter int NUM_WORDS = 2**ADDR_SIZE,
    parameter int MAX_BURST = 8
)(
    input  logic        clk,
    input  logic        rst,

    input  logic        host_req,
    input  logic        host_wr,
    input  logic [19:0] host_addr,
    input  logic [7:0]  host_wdata,
    output logic        host_ack,
    output logic        host_rd_valid,
    output logic [7:0]  host_rdata,

    input  logic        geo_req,
    input  logic        geo_wr,
    input  logic [19:0] geo_addr,
    input  logic [7:0]  geo_wdata,
    output logic        geo_ack,
    output logic        geo_rd_valid,
    output logic [7:0]  geo_rdata,

    output logic [19:0] ram_addr_b,
    output logic        ram_wr_en_b,
    output logic [7:0]  ram_data_in_b,
    input  logic [7:0]  ram_data_out_b
);

    localparam logic [7:0]  c_last_beat = 8'(MAX_BURST - 1);
    localparam logic [20:0] c_num_words = 21'(NUM_WORDS);

    arb_state_t  r_state;
    arb_state_t  w_next_state;
    logic [7:0]  r_burst_cnt;
    req_id_t     w_winner;

    logic        w_accept;
    req_id_t     w_acc_id;
    logic        w_acc_wr;
    logic [19:0] w_acc_addr;
    logic [7:0]  w_acc_wdata;
    logic        w_acc_in_range;

    logic        r_oob_d1;
    logic        r_oob_d2;
    logic [7:0]  r_rd_data;
    logic [7:0]  r_host_rdata_hold;
    logic [7:0]  r_geo_rdata_hold;

    logic        w_tag_valid;
    req_id_t     w_tag_id;

`ifdef GPU_RAM_ARB_ROUND_ROBIN_EN
    req_id_t     r_last_owner;

    always_comb begin
        w_winner = GEO;
        if (host_req && geo_req) begin
            if (r_last_owner == HOST) begin
                w_winner = GEO;
            end else begin
                w_winner = HOST;
            end
        end else if (host_req) begin
            w_winner = HOST;
        end
    end

    // Reset value GEO makes the first contested arbitration go to host.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_owner <= GEO;
        end else if (r_state == IDLE && (host_req || geo_req)) begin
            r_last_owner <= w_winner;
        end
    end
`else
    always_comb begin
        w_winner = GEO;
        if (host_req) begin
            w_winner = HOST;
        end
    end
`endif

    always_comb begin
        w_next_state = r_state;
        host_ack     = 1'b0;
        geo_ack      = 1'b0;
        case (r_state)
            IDLE: begin
                if (host_req || geo_req) begin
                    if (w_winner == HOST) begin
                        w_next_state = OWN_HOST;
                    end else begin
                        w_next_state = OWN_GEO;
                    end
                end
            end
            OWN_HOST: begin
                host_ack = host_req;
                if (!host_req || r_burst_cnt == c_last_beat) begin
                    w_next_state = IDLE;
                end
            end
            OWN_GEO: begin
                geo_ack = geo_req;
                if (!geo_req || r_burst_cnt == c_last_beat) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_acc_id    = HOST;
        w_acc_wr    = host_wr;
        w_acc_addr  = host_addr;
        w_acc_wdata = host_wdata;
        if (r_state == OWN_GEO) begin
            w_acc_id    = GEO;
            w_acc_wr    = geo_wr;
            w_acc_addr  = geo_addr;
            w_acc_wdata = geo_wdata;
        end
    end

    assign w_accept       = host_ack | geo_ack;
    assign w_acc_in_range = {1'b0, w_acc_addr} < c_num_words;

    // Every entry into OWN_x comes from IDLE, so clearing there covers it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_burst_cnt <= 8'd0;
        end else begin
            r_state <= w_next_state;
            if (r_state == IDLE) begin
                r_burst_cnt <= 8'd0;
            end else if (w_accept) begin
                r_burst_cnt <= r_burst_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_addr_b    <= 20'd0;
            ram_wr_en_b   <= 1'b0;
            ram_data_in_b <= 8'd0;
        end else begin
            ram_wr_en_b <= w_accept && w_acc_wr && w_acc_in_range;
            if (w_accept) begin
                ram_addr_b    <= w_acc_addr;
                ram_data_in_b <= w_acc_wdata;
            end
        end
    end

    // Out-of-range flag follows the address to the cycle RAM data appears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_oob_d1  <= 1'b0;
            r_oob_d2  <= 1'b0;
            r_rd_data <= 8'd0;
        end else begin
            r_oob_d1  <= w_accept && !w_acc_in_range;
            r_oob_d2  <= r_oob_d1;
            r_rd_data <= r_oob_d2 ? 8'd0 : ram_data_out_b;
        end
    end

    gpu_ram_rd_tag_pipe #(
        .DEPTH     (RD_LATENCY)
    ) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (w_accept && !w_acc_wr),
        .in_id     (w_acc_id),
        .out_valid (w_tag_valid),
        .out_id    (w_tag_id)
    );

    assign host_rd_valid = w_tag_valid && (w_tag_id == HOST);
    assign geo_rd_valid  = w_tag_valid && (w_tag_id == GEO);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_host_rdata_hold <= 8'd0;
            r_geo_rdata_hold  <= 8'd0;
        end else begin
            if (host_rd_valid) begin
                r_host_rdata_hold <= r_rd_data;
            end
            if (geo_rd_valid) begin
                r_geo_rdata_hold <= r_rd_data;
            end
        end
    end

    assign host_rdata = host_rd_valid ? r_rd_data : r_host_rdata_hold;
    assign geo_rdata  = geo_rd_valid  ? r_rd_data : r_geo_rdata_hold;

endmodule
`default_nettype wire

// File: tb/tb_gpu_ram_port_b_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpu_ram_port_b_arbiter
// Description : Self-checking bench for gpu_ram_port_b_arbiter with a RAM
//               model, reference memory and read-return scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpu_ram_port_b_arbiter;

`ifdef GPU_RAM_ARB_ROUND_ROBIN_EN
    localparam bit c_rr = 1'b1;
`else
    localparam bit c_rr = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        host_req, host_wr, host_ack, host_rd_valid;
    logic [19:0] host_addr;
    logic [7:0]  host_wdata, host_rdata;
    logic        geo_req, geo_wr, geo_ack, geo_rd_valid;
    logic [19:0] geo_addr;
    logic [7:0]  geo_wdata, geo_rdata;
    logic [19:0] ram_addr_b;
    logic        ram_wr_en_b;
    logic [7:0]  ram_data_in_b, ram_data_out_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t host_q[$];
    exp_t geo_q[$];
    exp_t mon_e;

    logic [7:0] mem     [16384];
    logic [7:0] ref_mem [16384];
    logic [7:0] ram_q;

    always #5 clk = ~clk;

    gpu_ram_port_b_arbiter #(
        .ADDR_SIZE      (14),
        .NUM_WORDS      (16384),
        .MAX_BURST      (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .host_req       (host_req),
        .host_wr        (host_wr),
        .host_addr      (host_addr),
        .host_wdata     (host_wdata),
        .host_ack       (host_ack),
        .host_rd_valid  (host_rd_valid),
        .host_rdata     (host_rdata),
        .geo_req        (geo_req),
        .geo_wr         (geo_wr),
        .geo_addr       (geo_addr),
        .geo_wdata      (geo_wdata),
        .geo_ack        (geo_ack),
        .geo_rd_valid   (geo_rd_valid),
        .geo_rdata      (geo_rdata),
        .ram_addr_b     (ram_addr_b),
        .ram_wr_en_b    (ram_wr_en_b),
        .ram_data_in_b  (ram_data_in_b),
        .ram_data_out_b (ram_data_out_b)
    );

    // Synchronous RAM: address registered at the edge, data out the next cycle.
    assign ram_data_out_b = ram_q;
    always @(posedge clk) begin
        if (ram_wr_en_b) mem[ram_addr_b[13:0]] <= ram_data_in_b;
        ram_q <= mem[ram_addr_b[13:0]];
        cyc   <= cyc + 1;
    end

    // Accept tracking feeds the scoreboard; returns are checked against it.
    always @(negedge clk) begin
        if (!rst) begin
            if (host_rd_valid) begin
                total++;
                if (host_q.size() == 0) begin
                    bad++;
                    $display("FAIL host_return: got unexpected pulse data=%h, want no pulse", host_rdata);
                end else begin
                    mon_e = host_q.pop_front();
                    if (host_rdata !== mon_e.data || cyc != mon_e.due) begin
                        bad++;
                        $display("FAIL host_return: got data=%h cycle=%0d, want data=%h cycle=%0d",
                                 host_rdata, cyc, mon_e.data, mon_e.due);
                    end
                end
            end
            if (geo_rd_valid) begin
                total++;
                if (geo_q.size() == 0) begin
                    bad++;
                    $display("FAIL geo_return: got unexpected pulse data=%h, want no pulse", geo_rdata);
                end else begin
                    mon_e = geo_q.pop_front();
                    if (geo_rdata !== mon_e.data || cyc != mon_e.due) begin
                        bad++;
                        $display("FAIL geo_return: got data=%h cycle=%0d, want data=%h cycle=%0d",
                                 geo_rdata, cyc, mon_e.data, mon_e.due);
                    end
                end
            end
            if (host_ack === 1'b1) begin
                if (!host_wr) host_q.push_back('{(host_addr < 20'h04000) ? ref_mem[host_addr[13:0]] : 8'h00, cyc + 3});
                else if (host_addr < 20'h04000) ref_mem[host_addr[13:0]] = host_wdata;
            end
            if (geo_ack === 1'b1) begin
                if (!geo_wr) geo_q.push_back('{(geo_addr < 20'h04000) ? ref_mem[geo_addr[13:0]] : 8'h00, cyc + 3});
                else if (geo_addr < 20'h04000) ref_mem[geo_addr[13:0]] = geo_wdata;
            end
        end
    end

    // Called at posedge+1; holds req until ack (bounded), then drops it.
    task automatic do_access(input bit is_geo, input bit wr, input logic [19:0] addr,
                             input logic [7:0] wdata, output bit got, output int ack_cyc);
        got = 1'b0;
        ack_cyc = -1;
        if (is_geo) begin
            geo_req = 1'b1; geo_wr = wr; geo_addr = addr; geo_wdata = wdata;
        end else begin
            host_req = 1'b1; host_wr = wr; host_addr = addr; host_wdata = wdata;
        end
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if ((is_geo ? geo_ack : host_ack) === 1'b1) begin
                got = 1'b1;
                ack_cyc = cyc;
            end
        end
        @(posedge clk); #1;
        host_req = 1'b0;
        geo_req  = 1'b0;
    endtask

    task automatic test_reset();
        string       nm [9];
        logic [19:0] v  [9];
        rst = 1'b1;
        host_req = 1'b1; host_wr = 1'b0; host_addr = 20'h00010; host_wdata = 8'h00;
        geo_req  = 1'b1; geo_wr  = 1'b0; geo_addr  = 20'h00020; geo_wdata  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        nm = '{"host_ack", "geo_ack", "ram_addr_b", "ram_wr_en_b", "ram_data_in_b",
               "host_rd_valid", "geo_rd_valid", "host_rdata", "geo_rdata"};
        v  = '{20'(host_ack), 20'(geo_ack), ram_addr_b, 20'(ram_wr_en_b), 20'(ram_data_in_b),
               20'(host_rd_valid), 20'(geo_rd_valid), 20'(host_rdata), 20'(geo_rdata)};
        for (int i = 0; i < 9; i++) begin
            total++;
            if (v[i] !== 20'd0) begin
                bad++;
                $display("FAIL reset_%s: got %0h, want 0", nm[i], v[i]);
            end
        end
        host_req = 1'b0;
        geo_req  = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        int c0;
        host_req = 1'b1; host_wr = 1'b0; host_addr = 20'h00010;
        @(negedge clk);
        total++;
        if (host_ack !== 1'b0) begin
            bad++; $display("FAIL idle_no_ack: got host_ack=%b, want 0", host_ack);
        end
        c0 = cyc;
        @(negedge clk);
        total++;
        if (host_ack !== 1'b1 || cyc != c0 + 1) begin
            bad++; $display("FAIL read_ack: got host_ack=%b at cycle %0d, want 1 at %0d", host_ack, cyc, c0 + 1);
        end
        @(posedge clk); #1;
        host_req = 1'b0;
        @(negedge clk);
        total++;
        if (ram_addr_b !== 20'h00010 || ram_wr_en_b !== 1'b0) begin
            bad++; $display("FAIL read_ram_port: got addr=%h we=%b, want addr=00010 we=0", ram_addr_b, ram_wr_en_b);
        end
        repeat (2) @(negedge clk);
        total++;
        if (host_rd_valid !== 1'b1 || host_rdata !== 8'h5A) begin
            bad++; $display("FAIL read_return: got valid=%b data=%h, want valid=1 data=5a", host_rd_valid, host_rdata);
        end
        @(negedge clk);
        total++;
        if (host_rd_valid !== 1'b0 || host_rdata !== 8'h5A) begin
            bad++; $display("FAIL rdata_hold: got valid=%b data=%h, want valid=0 data=5a", host_rd_valid, host_rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_burst_arbitration();
        logic [1:0] exp_ack;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        host_req = 1'b1; host_wr = 1'b0; host_addr = 20'h00100;
        geo_req  = 1'b1; geo_wr  = 1'b0; geo_addr  = 20'h00200;
        for (int k = 0; k < 36; k++) begin
            @(negedge clk);
            exp_ack = 2'b00;
            if (k % 9 != 0) exp_ack = ((k / 9) % 2 == 0 || !c_rr) ? 2'b10 : 2'b01;
            total++;
            if ({host_ack, geo_ack} !== exp_ack) begin
                bad++;
                $display("FAIL burst_pattern[%0d]: got host/geo ack=%b, want %b", k, {host_ack, geo_ack}, exp_ack);
            end
        end
        @(posedge clk); #1;
        host_req = 1'b0;
        geo_req  = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_boundary();
        bit got;
        int n;
        do_access(1'b1, 1'b1, 20'h03FFF, 8'hA5, got, n);
        total++;
        if (!got) begin bad++; $display("FAIL top_write_ack: got no ack, want ack"); end
        @(negedge clk);
        total++;
        if (ram_wr_en_b !== 1'b1 || ram_addr_b !== 20'h03FFF || ram_data_in_b !== 8'hA5) begin
            bad++; $display("FAIL top_write_port: got we=%b addr=%h data=%h, want we=1 addr=03fff data=a5",
                            ram_wr_en_b, ram_addr_b, ram_data_in_b);
        end
        @(posedge clk); #1;
        do_access(1'b0, 1'b0, 20'h03FFF, 8'h00, got, n);
        repeat (4) @(negedge clk);
        total++;
        if (host_rdata !== 8'hA5) begin
            bad++; $display("FAIL top_readback: got %h, want a5", host_rdata);
        end
        @(posedge clk); #1;
        do_access(1'b1, 1'b1, 20'h04000, 8'h77, got, n);
        total++;
        if (!got) begin bad++; $display("FAIL oob_write_ack: got no ack, want ack"); end
        @(negedge clk);
        total++;
        if (ram_wr_en_b !== 1'b0) begin
            bad++; $display("FAIL oob_write_we: got we=%b, want 0", ram_wr_en_b);
        end
        @(posedge clk); #1;
        do_access(1'b0, 1'b0, 20'h04000, 8'h00, got, n);
        repeat (4) @(negedge clk);
        total++;
        if (host_rdata !== 8'h00) begin
            bad++; $display("FAIL oob_read_zero: got %h, want 00", host_rdata);
        end
        @(posedge clk); #1;
        do_access(1'b1, 1'b0, 20'hFFFFF, 8'h00, got, n);
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int acks = 0, first = -1, last = -1, geo_first = -1, pulses = 0;
        host_req = 1'b1; host_wr = 1'b0; host_addr = 20'h00020;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (host_ack === 1'b1) begin
                acks++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            if (geo_ack === 1'b1 && geo_first < 0) geo_first = cyc;
            if (host_rd_valid === 1'b1) pulses++;
            @(posedge clk); #1;
            host_addr = 20'h00020 + 20'(acks);
            if (acks == 3 && host_req) begin
                host_req = 1'b0;
                geo_req = 1'b1; geo_wr = 1'b0; geo_addr = 20'h00030;
            end
            if (geo_first >= 0) geo_req = 1'b0;
        end
        total++;
        if (acks != 3 || last - first != 2) begin
            bad++; $display("FAIL b2b_acks: got %0d acks over %0d cycles, want 3 over 2", acks, last - first);
        end
        total++;
        if (geo_first != last + 3) begin
            bad++; $display("FAIL b2b_idle_gap: got geo ack at cycle %0d, want %0d", geo_first, last + 3);
        end
        total++;
        if (pulses != 3) begin
            bad++; $display("FAIL b2b_returns: got %0d pulses, want 3", pulses);
        end
        geo_req = 1'b0;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_inflight();
        bit got;
        int n, pulses = 0;
        do_access(1'b0, 1'b0, 20'h00040, 8'h00, got, n);
        rst = 1'b1;
        host_q.delete();
        geo_q.delete();
        #1;
        total++;
        if (ram_addr_b !== 20'd0 || ram_wr_en_b !== 1'b0 || host_rd_valid !== 1'b0 || host_rdata !== 8'h00) begin
            bad++; $display("FAIL rst_async: got addr=%h we=%b valid=%b data=%h, want all 0",
                            ram_addr_b, ram_wr_en_b, host_rd_valid, host_rdata);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (host_rd_valid === 1'b1 || geo_rd_valid === 1'b1) pulses++;
        end
        total++;
        if (pulses != 0) begin
            bad++; $display("FAIL rst_drop_inflight: got %0d pulses, want 0", pulses);
        end
        @(posedge clk); #1;
        host_req = 1'b1; host_wr = 1'b0; host_addr = 20'h00050;
        geo_req  = 1'b1; geo_wr  = 1'b0; geo_addr  = 20'h00060;
        repeat (2) @(negedge clk);
        total++;
        if ({host_ack, geo_ack} !== 2'b10) begin
            bad++; $display("FAIL rst_first_winner: got host/geo ack=%b, want 10", {host_ack, geo_ack});
        end
        @(posedge clk); #1;
        host_req = 1'b0;
        geo_req  = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) begin
            mem[i]     = 8'(i) ^ 8'h3C;
            ref_mem[i] = 8'(i) ^ 8'h3C;
        end
        mem[16]     = 8'h5A;
        ref_mem[16] = 8'h5A;
        ram_q       = 8'h00;
        rst = 1'b1;
        host_req = 1'b0; host_wr = 1'b0; host_addr = 20'd0; host_wdata = 8'd0;
        geo_req  = 1'b0; geo_wr  = 1'b0; geo_addr  = 20'd0; geo_wdata  = 8'd0;

        test_reset();
        test_single_read();
        test_burst_arbitration();
        test_boundary();
        test_back_to_back();
        test_reset_inflight();

        total++;
        if (host_q.size() != 0 || geo_q.size() != 0) begin
            bad++; $display("FAIL scoreboard_drain: got %0d host / %0d geo pending, want 0/0", host_q.size(), geo_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
